// File: rtl/wb_pkg.sv
// ============================================================================
// Module      : wb_pkg
// Description : Shared types and constants for the writeback sequencer.
//               Holds the FSM state encoding, the decoded write operation
//               encoding and the default register-file size.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package wb_pkg;

    // Default number of architectural registers (must be a power of two)
    localparam int REG_COUNT_DEFAULT = 16;

    // Number of lanes moved by a quad write
    localparam int LANES = 4;

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_BURST = 1'b1
    } wb_state_t;

    typedef enum logic [2:0] {
        OP_NONE    = 3'd0,
        OP_POS     = 3'd1,
        OP_PXL     = 3'd2,
        OP_MUL_POS = 3'd3,
        OP_MUL_REG = 3'd4
    } wb_op_t;

endpackage : wb_pkg

`default_nettype wire

// File: rtl/wb_write_sequencer_if.sv
// ============================================================================
// Module      : wb_write_sequencer_if
// Description : MEM/WB bundle handshake plus register-file write port.
//               master : upstream pipeline / register file side
//               slave  : the writeback sequencer
// Signals     : in_valid/in_ready handshake, write flags, rd, r1..r4,
//               load1..load4 in; rf_we/rf_waddr/rf_wdata, busy,
//               conflict_err out of the sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface wb_write_sequencer_if #(
    parameter int AW = $clog2(wb_pkg::REG_COUNT_DEFAULT)
) ();

    logic          in_valid;
    logic          in_ready;
    logic          wr_pxl;
    logic          wr_pos;
    logic          wr_mul_reg;
    logic          wr_mul_pos;
    logic [AW-1:0] rd;
    logic [31:0]   r1, r2, r3, r4;
    logic [31:0]   load1, load2, load3, load4;
    logic          rf_we;
    logic [AW-1:0] rf_waddr;
    logic [31:0]   rf_wdata;
    logic          busy;
    logic          conflict_err;

    modport master (
        output in_valid, wr_pxl, wr_pos, wr_mul_reg, wr_mul_pos, rd,
               r1, r2, r3, r4, load1, load2, load3, load4,
        input  in_ready, rf_we, rf_waddr, rf_wdata, busy, conflict_err
    );

    modport slave (
        input  in_valid, wr_pxl, wr_pos, wr_mul_reg, wr_mul_pos, rd,
               r1, r2, r3, r4, load1, load2, load3, load4,
        output in_ready, rf_we, rf_waddr, rf_wdata, busy, conflict_err
    );

endinterface : wb_write_sequencer_if

`default_nettype wire

// File: rtl/wb_op_decode.sv
// ============================================================================
// Module      : wb_op_decode
// Description : Combinational priority encoder for the writeback flags.
//               Priority: wr_mul_reg > wr_mul_pos > wr_pxl > wr_pos.
// Ports       : wr_*_i  - raw write flags
//               op_o    - decoded operation
//               multi_o - two or more flags asserted together
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module wb_op_decode
    import wb_pkg::*;
(
    input  logic   wr_pxl_i,
    input  logic   wr_pos_i,
    input  logic   wr_mul_reg_i,
    input  logic   wr_mul_pos_i,
    output wb_op_t op_o,
    output logic   multi_o
);

    logic [2:0] flag_cnt;

    assign flag_cnt = {2'b00, wr_pxl_i} + {2'b00, wr_pos_i}
                    + {2'b00, wr_mul_reg_i} + {2'b00, wr_mul_pos_i};

    assign multi_o = (flag_cnt >= 3'd2);

    always_comb begin
        op_o = OP_NONE;
        if (wr_mul_reg_i) begin
            op_o = OP_MUL_REG;
        end else if (wr_mul_pos_i) begin
            op_o = OP_MUL_POS;
        end else if (wr_pxl_i) begin
            op_o = OP_PXL;
        end else if (wr_pos_i) begin
            op_o = OP_POS;
        end
    end

endmodule : wb_op_decode

`default_nettype wire

// File: rtl/wb_write_sequencer.sv
// ============================================================================
// Module      : wb_write_sequencer
// Description : Writeback stage. Turns MEM/WB bundles into single-port
//               register-file writes; quad writes are serialized over four
//               consecutive cycles while upstream is held off via in_ready.
// Ports       : clk  - rising-edge clock
//               rst  - asynchronous, active-low reset
//               bus  - slave modport: bundle handshake in, rf write port,
//                      busy and sticky conflict_err out
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module wb_write_sequencer
    import wb_pkg::*;
#(
    parameter int REG_COUNT = REG_COUNT_DEFAULT,
    parameter int AW        = $clog2(REG_COUNT)
) (
    input  logic                 clk,
    input  logic                 rst,
    wb_write_sequencer_if.slave  bus
);

    wb_state_t               state_q, state_d;
    logic [1:0]              lane_q, lane_d;
    logic [LANES-1:0][31:0]  lane_buf_q, lane_buf_d;
    logic [AW-1:0]           base_q, base_d;
    logic                    rf_we_q, rf_we_d;
    logic [AW-1:0]           rf_waddr_q, rf_waddr_d;
    logic [31:0]             rf_wdata_q, rf_wdata_d;
    logic                    conflict_q, conflict_d;

    wb_op_t                  op;
    logic                    multi;
    logic                    accept;
    logic                    is_quad;
    logic [LANES-1:0][31:0]  sel_lanes;

    wb_op_decode u_decode (
        .wr_pxl_i     (bus.wr_pxl),
        .wr_pos_i     (bus.wr_pos),
        .wr_mul_reg_i (bus.wr_mul_reg),
        .wr_mul_pos_i (bus.wr_mul_pos),
        .op_o         (op),
        .multi_o      (multi)
    );

    // in_ready is gated by rst so nothing is accepted while reset is held
    assign bus.in_ready = rst && (state_q == S_IDLE);
    assign accept       = bus.in_valid && bus.in_ready;
    assign is_quad      = (op == OP_MUL_REG) || (op == OP_MUL_POS);
    assign sel_lanes    = (op == OP_MUL_REG)
                        ? {bus.load4, bus.load3, bus.load2, bus.load1}
                        : {bus.r4, bus.r3, bus.r2, bus.r1};

    // ---------------- state register ----------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            lane_q     <= 2'd0;
            lane_buf_q <= '0;
            base_q     <= '0;
            rf_we_q    <= 1'b0;
            rf_waddr_q <= '0;
            rf_wdata_q <= '0;
            conflict_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            lane_q     <= lane_d;
            lane_buf_q <= lane_buf_d;
            base_q     <= base_d;
            rf_we_q    <= rf_we_d;
            rf_waddr_q <= rf_waddr_d;
            rf_wdata_q <= rf_wdata_d;
            conflict_q <= conflict_d;
        end
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        state_d = state_q;
        lane_d  = lane_q;
        case (state_q)
            S_IDLE: begin
                // Lane 0 goes out straight from the inputs, so the burst
                // picks up at lane 1.
                if (accept && is_quad) begin
                    state_d = S_BURST;
                    lane_d  = 2'd1;
                end
            end
            S_BURST: begin
                if (lane_q == 2'd3) begin
                    state_d = S_IDLE;
                    lane_d  = 2'd0;
                end else begin
                    lane_d = lane_q + 2'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
                lane_d  = 2'd0;
            end
        endcase
    end

    // ---------------- output / datapath logic ----------------
    always_comb begin
        rf_we_d    = 1'b0;
        rf_waddr_d = rf_waddr_q;
        rf_wdata_d = rf_wdata_q;
        lane_buf_d = lane_buf_q;
        base_d     = base_q;
        conflict_d = conflict_q | (accept & multi);

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    case (op)
                        OP_POS: begin
                            rf_we_d    = 1'b1;
                            rf_waddr_d = bus.rd;
                            rf_wdata_d = bus.r1;
                        end
                        OP_PXL: begin
                            rf_we_d    = 1'b1;
                            rf_waddr_d = bus.rd;
                            rf_wdata_d = bus.load1;
                        end
                        OP_MUL_POS, OP_MUL_REG: begin
                            rf_we_d    = 1'b1;
                            rf_waddr_d = bus.rd;
                            rf_wdata_d = sel_lanes[0];
                            lane_buf_d = sel_lanes;
                            base_d     = bus.rd;
                        end
                        default: ;  // bubble: consumed, nothing written
                    endcase
                end
            end
            S_BURST: begin
                // AW-bit add wraps naturally modulo REG_COUNT
                rf_we_d    = 1'b1;
                rf_waddr_d = base_q + AW'(lane_q);
                rf_wdata_d = lane_buf_q[lane_q];
            end
            default: ;
        endcase
    end

    assign bus.rf_we        = rf_we_q;
    assign bus.rf_waddr     = rf_waddr_q;
    assign bus.rf_wdata     = rf_wdata_q;
    assign bus.busy         = (state_q == S_BURST);
    assign bus.conflict_err = conflict_q;

endmodule : wb_write_sequencer

`default_nettype wire

// File: tb/tb_wb_write_sequencer.sv
// ============================================================================
// Module      : tb_wb_write_sequencer
// Description : Scoreboard bench for wb_write_sequencer. The driver pushes
//               the expected register-file writes for each accepted bundle;
//               a negedge monitor pops and compares every emitted write and
//               checks in_ready/busy/conflict_err against the model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_wb_write_sequencer;
    import wb_pkg::*;

    localparam int REG_COUNT = 16;
    localparam int AW        = 4;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [31:0]   data;
    } wr_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    wb_write_sequencer_if #(.AW(AW)) bus ();

    wb_write_sequencer #(.REG_COUNT(REG_COUNT), .AW(AW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    wr_t  exp_q[$];
    wr_t  mon_e;
    logic exp_conflict = 1'b0;
    bit   mon_en       = 1'b0;
    int   checks       = 0;
    int   errors       = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: expected writes from the flag rules, plain arithmetic
    function automatic void model_push(input logic [3:0] flags, input logic [AW-1:0] rd,
                                       input logic [3:0][31:0] r, input logic [3:0][31:0] ld);
        wr_t w;
        if ($countones(flags) >= 2) exp_conflict = 1'b1;
        if (flags[3] || flags[2]) begin
            for (int k = 0; k < 4; k++) begin
                w.addr = AW'((int'(rd) + k) % REG_COUNT);
                w.data = flags[3] ? ld[k] : r[k];
                exp_q.push_back(w);
            end
        end else if (flags[1]) begin
            w.addr = rd; w.data = ld[0]; exp_q.push_back(w);
        end else if (flags[0]) begin
            w.addr = rd; w.data = r[0]; exp_q.push_back(w);
        end
    endfunction

    // Monitor: one look per cycle, well away from the rising edge
    always @(negedge clk) begin
        if (mon_en) begin
            if (bus.rf_we) begin
                if (exp_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_write: got addr %0d data 0x%0h, required none at %0t",
                             bus.rf_waddr, bus.rf_wdata, $time);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("rf_waddr", 32'(bus.rf_waddr), 32'(mon_e.addr));
                    check("rf_wdata", bus.rf_wdata, mon_e.data);
                end
            end else if (exp_q.size() != 0) begin
                checks++; errors++;
                $display("FAIL missing_write: got rf_we=0, required write addr %0d at %0t",
                         exp_q[0].addr, $time);
            end
            check("in_ready", 32'(bus.in_ready), 32'(rst && (exp_q.size() == 0)));
            check("busy", 32'(bus.busy), 32'(exp_q.size() != 0));
            check("conflict_err", 32'(bus.conflict_err), 32'(exp_conflict));
        end
    end

    task automatic drive_idle(input int n);
        bus.in_valid = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Called and returns at posedge+1; acc_time is the accept edge time
    task automatic send(input logic [3:0] flags, input logic [AW-1:0] rd,
                        input logic [3:0][31:0] r, input logic [3:0][31:0] ld,
                        output time acc_time);
        bit ok = 1'b0;
        int waited = 0;
        bus.in_valid   = 1'b1;
        bus.wr_mul_reg = flags[3];
        bus.wr_mul_pos = flags[2];
        bus.wr_pxl     = flags[1];
        bus.wr_pos     = flags[0];
        bus.rd         = rd;
        {bus.r4, bus.r3, bus.r2, bus.r1}             = r;
        {bus.load4, bus.load3, bus.load2, bus.load1} = ld;
        acc_time = 0;
        while (!ok && waited <= 20) begin
            @(negedge clk); #1;
            ok = bus.in_ready;
            if (!ok) begin
                waited++;
                @(posedge clk); #1;
            end
        end
        if (!ok) begin
            checks++; errors++;
            $display("FAIL accept_timeout: got no accept in %0d cycles, required accept", waited);
        end else begin
            model_push(flags, rd, r, ld);
            @(posedge clk);
            acc_time = $time;
            #1;
        end
        bus.in_valid = 1'b0;
    endtask

    initial begin
        time t0, t1;
        logic [3:0]       fl;
        logic [3:0][31:0] rr, ll;

        bus.in_valid = 1'b0; bus.wr_pxl = 1'b0; bus.wr_pos = 1'b0;
        bus.wr_mul_reg = 1'b0; bus.wr_mul_pos = 1'b0; bus.rd = '0;
        {bus.r4, bus.r3, bus.r2, bus.r1} = '0;
        {bus.load4, bus.load3, bus.load2, bus.load1} = '0;

        repeat (3) @(posedge clk);
        #1;
        check("reset_rf_we", 32'(bus.rf_we), 0);
        check("reset_rf_waddr", 32'(bus.rf_waddr), 0);
        check("reset_rf_wdata", bus.rf_wdata, 0);
        check("reset_busy", 32'(bus.busy), 0);
        check("reset_in_ready", 32'(bus.in_ready), 0);
        check("reset_conflict", 32'(bus.conflict_err), 0);

        @(negedge clk); #2;
        rst    = 1'b1;
        mon_en = 1'b1;
        @(posedge clk); #1;

        // Single wr_pos
        send(4'b0001, 4'd5, {32'd0, 32'd0, 32'd0, 32'hDEADBEEF}, '0, t0);
        drive_idle(2);
        // Quad wr_mul_reg
        send(4'b1000, 4'd2, '0, {32'h44, 32'h33, 32'h22, 32'h11}, t0);
        drive_idle(5);
        // Quad wr_mul_pos with address wrap
        send(4'b0100, 4'd14, {32'd4, 32'd3, 32'd2, 32'd1}, '0, t0);
        drive_idle(5);
        // Conflicting flags: wr_pxl wins, conflict_err sticks
        send(4'b0011, 4'd7, {32'd0, 32'd0, 32'd0, 32'hBB}, {32'd0, 32'd0, 32'd0, 32'hAA}, t0);
        drive_idle(10);
        check("conflict_sticky", 32'(bus.conflict_err), 1);

        // Back-to-back quads: second accepted exactly four edges later
        send(4'b1000, 4'd0, '0, {32'hA3, 32'hA2, 32'hA1, 32'hA0}, t0);
        send(4'b0100, 4'd12, {32'hB3, 32'hB2, 32'hB1, 32'hB0}, '0, t1);
        check("b2b_accept_gap", 32'(int'((t1 - t0) / 10)), 4);
        drive_idle(6);

        // Reset after lane 1 of a burst
        send(4'b1000, 4'd9, '0, {32'hC3, 32'hC2, 32'hC1, 32'hC0}, t0);
        @(negedge clk);   // lane 0 on outputs
        @(negedge clk);   // lane 1 on outputs
        #2;
        rst = 1'b0;
        exp_q.delete();
        exp_conflict = 1'b0;
        #1;
        check("rst_mid_rf_we", 32'(bus.rf_we), 0);
        check("rst_mid_rf_waddr", 32'(bus.rf_waddr), 0);
        check("rst_mid_rf_wdata", bus.rf_wdata, 0);
        check("rst_mid_busy", 32'(bus.busy), 0);
        check("rst_mid_in_ready", 32'(bus.in_ready), 0);
        check("rst_mid_conflict", 32'(bus.conflict_err), 0);
        @(negedge clk); #2;
        rst = 1'b1;
        #1;
        check("rst_release_in_ready", 32'(bus.in_ready), 1);
        @(posedge clk); #1;
        drive_idle(6);

        // Randomized traffic
        for (int i = 0; i < 300; i++) begin
            for (int b = 0; b < 4; b++) fl[b] = ($urandom_range(0, 9) < 2);
            for (int b = 0; b < 4; b++) begin
                rr[b] = $urandom;
                ll[b] = $urandom;
            end
            send(fl, AW'($urandom_range(0, REG_COUNT - 1)), rr, ll, t0);
            if ($urandom_range(0, 2) == 0) drive_idle($urandom_range(1, 3));
        end
        drive_idle(8);
        mon_en = 1'b0;
        check("queue_drained", 32'(exp_q.size()), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_wb_write_sequencer

`default_nettype wire
